// File: rtl/ipgu_pkg.sv
// ipgu_pkg: window geometry, pixel/window types and bank state for the IPGU window buffer
package ipgu_pkg;
  localparam int WIN_ROWS = 5;
  localparam int WIN_COLS = 80;
  localparam int PIX_W = 8;
  localparam int BEATS = 80;
  localparam int CNT_W = $clog2(BEATS);
  typedef logic [PIX_W-1:0] pixel_t;
  typedef pixel_t [WIN_ROWS-1:0][WIN_COLS-1:0] window_t;
  typedef logic [CNT_W-1:0] beat_t;
  typedef enum logic [1:0] {EMPTY, FILL, FULL} bank_state_t;
endpackage

// File: rtl/ipgu_wbuf_if.sv
// ipgu_wbuf_if: IPGU beat stream in, HEU window handoff out
interface ipgu_wbuf_if;
  import ipgu_pkg::*;
  logic in_valid;
  logic [WIN_ROWS*PIX_W-1:0] in_data;
  logic in_last;
  logic in_ready;
  logic heu_in_ready;
  logic ipgu_out_ready;
  window_t q;
  logic frame_err;
  modport master (
    output in_valid, in_data, in_last, heu_in_ready,
    input  in_ready, ipgu_out_ready, q, frame_err
  );
  modport slave (
    input  in_valid, in_data, in_last, heu_in_ready,
    output in_ready, ipgu_out_ready, q, frame_err
  );
endinterface

// File: rtl/ipgu_wbank.sv
// ipgu_wbank: one 400-pixel window bank written a column per beat, cleared by reset
module ipgu_wbank
  import ipgu_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we_i,
  input  beat_t                     col_i,
  input  logic [WIN_ROWS*PIX_W-1:0] din_i,
  output window_t                   q_o
);
  window_t mem_q;
  // each accepted beat writes all rows of one column
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mem_q <= '0;
    else if (we_i)
      for (int k = 0; k < WIN_ROWS; k++) mem_q[k][col_i] <= din_i[k*PIX_W +: PIX_W];
  assign q_o = mem_q;
endmodule

// File: rtl/ipgu_wbuf.sv
// ipgu_wbuf: double-buffered 20x20 window assembler handing full windows to the HEU
module ipgu_wbuf
  import ipgu_pkg::*;
(
  input logic          clk,
  input logic          rst_n,
  ipgu_wbuf_if.slave   bus
);
  bank_state_t st_q [2];
  bank_state_t st_d [2];
  logic wptr_q, wptr_d, rptr_q, rptr_d, psel_q, psel_d;
  logic pulse_q, pulse_d, err_q, err_d;
  beat_t bcnt_q, bcnt_d;
  logic acc, last_beat, good, bad, fire;
  window_t q0, q1;
  assign bus.in_ready = st_q[wptr_q] != FULL;
  assign acc = bus.in_valid && bus.in_ready;
  assign last_beat = bcnt_q == beat_t'(BEATS - 1);
  assign good = acc && last_beat && bus.in_last;
  assign bad = acc && (bus.in_last ^ last_beat);
  assign fire = st_q[rptr_q] == FULL && bus.heu_in_ready && !pulse_q;
  assign bus.ipgu_out_ready = pulse_q;
  assign bus.frame_err = err_q;
  assign bus.q = psel_q ? q1 : q0;
  // bank bookkeeping: the pulse frees the presented bank, beats advance the write bank
  always_comb begin
    st_d = st_q;
    if (pulse_q) st_d[psel_q] = EMPTY;
    if (acc) st_d[wptr_q] = good ? FULL : bad ? EMPTY : FILL;
    wptr_d = wptr_q ^ good;
    rptr_d = rptr_q ^ pulse_q;
    psel_d = fire ? rptr_q : psel_q;
    pulse_d = fire;
    err_d = bad;
    bcnt_d = !acc ? bcnt_q : (good || bad) ? '0 : bcnt_q + 1'b1;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_q <= '{EMPTY, EMPTY};
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      psel_q <= 1'b0;
      pulse_q <= 1'b0;
      err_q <= 1'b0;
      bcnt_q <= '0;
    end else begin
      st_q <= st_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      psel_q <= psel_d;
      pulse_q <= pulse_d;
      err_q <= err_d;
      bcnt_q <= bcnt_d;
    end
  ipgu_wbank u_bank0 (
    .clk   (clk),
    .rst_n (rst_n),
    .we_i  (acc && !wptr_q),
    .col_i (bcnt_q),
    .din_i (bus.in_data),
    .q_o   (q0)
  );
  ipgu_wbank u_bank1 (
    .clk   (clk),
    .rst_n (rst_n),
    .we_i  (acc && wptr_q),
    .col_i (bcnt_q),
    .din_i (bus.in_data),
    .q_o   (q1)
  );
endmodule

// File: doc/ipgu_wbuf.md
# ipgu_wbuf

Double-buffered window assembler between the image-pyramid generation unit (IPGU) pixel stream and the histogram equalization unit (HEU). It collects a 20x20 window (400 8-bit pixels) arriving as 80 beats of 5 pixels, stores it in one of two banks, and hands the full window to the HEU. The handoff is a one-cycle `ipgu_out_ready` pulse with the window held stable on `q`. One bank can fill while the other waits for the HEU, so upstream streaming overlaps HEU processing.

## Interface
- Parameters: none. Geometry is fixed by package constants (`WIN_ROWS`=5, `WIN_COLS`=80, `PIX_W`=8).
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset. Asynchronous assert, active-low.
- `in_valid`  in  1  beat valid from the IPGU pixel stream.
- `in_data`  in  40  five pixels; `in_data[8k+7:8k]` is row k of the current column.
- `in_last`  in  1  marks the final beat of a window. Legal only on beat 79.
- `in_ready`  out  1  beat accepted on an edge where `in_valid && in_ready`.
- `heu_in_ready`  in  1  HEU is idle and can capture a window (HEU `in_ready`).
- `ipgu_out_ready`  out  1  one-cycle pulse; the HEU captures `q` on this edge.
- `q`  out  8 x [4:0][79:0]  window pixels, `q[k][j]` = row k, column j. Drives the HEU `d`.
- `frame_err`  out  1  one-cycle pulse when a malformed window is discarded.

## Operation
- **Beat order:** beat j (0..79) writes `bank[wptr][k][j] = in_data[8k+7:8k]` for k=0..4.
- **Bank state:** each bank is EMPTY, FILL, or FULL.
- **Write pointer `wptr`:**
  - `in_ready` = bank[wptr] != FULL.
  - First accepted beat moves the bank EMPTY->FILL.
  - Beat counter `bcnt` counts 0..79.
- **Good window:** beat 79 accepted with `in_last`=1. The bank goes FULL, `wptr` toggles, `bcnt`->0.
- **Error, early last:** `in_last`=1 on beat j<79. The window is discarded: bank->EMPTY, `bcnt`->0, `wptr` unchanged, `frame_err` pulses.
- **Error, missing last:** beat 79 accepted with `in_last`=0. Handled identically to early last.
- **Read pointer `rptr`:** windows are presented in fill order.
  - If bank[rptr]==FULL, `heu_in_ready`=1, and `ipgu_out_ready` is currently 0, then on the next edge:
    - `ipgu_out_ready`<=1
    - `psel`<=`rptr`
  - On the edge ending the pulse:
    - `ipgu_out_ready`<=0
    - bank[psel]->EMPTY
    - `rptr` toggles
- **Output mux:** `q` is combinational from bank[`psel`]. It holds the last presented window between pulses.
- **Pulse spacing:** back-to-back pulses are impossible; there is at least one low cycle between pulses.
- **Same-cycle events:**
  - A bank freed on the same edge it becomes the write target is visible to `in_ready` only from the next cycle, because state is registered.
  - A final beat and a read handoff on the same edge are independent, since they always touch different banks.

## Timing
- **Reset values:**
  - `in_ready`=1
  - `ipgu_out_ready`=0
  - `frame_err`=0
  - `q`=0 (banks cleared)
  - `wptr`=`rptr`=`psel`=0, `bcnt`=0, both banks EMPTY
- **Latency:** final beat accepted at edge E, with `heu_in_ready`=1 during cycle E..E+1. The pulse is high for exactly the cycle between edges E+1 and E+2.
- **Back-pressure:** if `heu_in_ready` stays 0, the pulse is delayed indefinitely. The window stays FULL and `q` is unchanged.
- **Full condition:** both banks FULL. `in_ready`=0 until the edge ending the next pulse; it is high in the following cycle.
- **Throughput:** 1 beat/cycle with `in_valid` held high and the HEU keeping up. `in_valid` gaps are allowed on any cycle.
- **Error flag:** `frame_err` is registered and high for the one cycle after the offending beat's edge.
- **Reset mid-operation:** asserting `rst_n` low immediately forces all reset values. Partial windows are dropped and no pulse follows.

## Structure
- **Package `ipgu_pkg`:**
  - `WIN_ROWS`, `WIN_COLS`, `PIX_W`, `BEATS`=80
  - typedef `pixel_t` (8-bit)
  - typedef `window_t` (`pixel_t [4:0][79:0]`)
  - enum `bank_state_t` {EMPTY, FILL, FULL}
- **Sub-module `ipgu_wbank`:** one 400-pixel bank with column write enable and async-reset clear. Instantiated twice; the top holds the pointers, the counter and the handshake FSM.

## Test plan
- **Single window:** pixel(k,j)=(k*80+j)&8'hFF, `in_last` on beat 79, `heu_in_ready`=1.
  - One `ipgu_out_ready` pulse, 2 edges after the last beat.
  - `q[k][j]` matches every pixel; `frame_err` stays 0.
- **Back-pressure:** `heu_in_ready`=0; stream windows W0 (all 8'h11), W1 (8'h22), W2 (8'h33).
  - `in_ready` drops after beat 159; W2 stalls.
  - Raising `heu_in_ready` gives pulses with `q`=W0 then W1, spaced ≥2 cycles.
  - W2 then completes.
- **Early last:** `in_last` on beat 40, then a clean window of 8'hA5.
  - One `frame_err` pulse and no `ipgu_out_ready` for the bad window.
  - Next pulse shows all 8'hA5.
- **Missing last:** 80 beats with no `in_last` → `frame_err` pulse, window discarded, `in_ready` still 1.
- **Reset mid-window:** assert `rst_n`=0 at beat 30, release, send a full 8'h5A window.
  - Outputs hold reset values during reset.
  - Single pulse with all `q`=8'h5A and no residue.
- **Random stress:** `in_valid` at 60% duty and `heu_in_ready` toggling randomly, 50 random windows → every window presented once, in order, bit-exact.
